// File: rtl/adder_tpg_pkg.sv
// Shared types and constants for the adder test-pattern generator.
package adder_tpg_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_TOGGLE = 2'd3
    } tpg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tpg_state_e;

    // Galois feedback mask (right-shift form) for each supported width.
    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_A300_0000;
            64:      return 64'hD800_0000_0000_0000;
            default: return 64'h0;
        endcase
    endfunction

endpackage

// File: rtl/adder_tpg_lfsr.sv
// WIDTH-generic Galois LFSR, right-shifting. Load wins over advance.
// state_next is the value one advance ahead, so the caller can register
// it into its own output flops on the same edge the LFSR steps.
module adder_tpg_lfsr
    import adder_tpg_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             advance,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_next
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Next-state: one Galois step, or a reload from seed.
    always_comb begin
        state_next = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        state_d    = state_q;
        if (load) begin
            state_d = seed;
        end else if (advance) begin
            state_d = state_next;
        end
    end

    // State register; reset returns to the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/adder_tpg_gen.sv
// Burst test-pattern generator for adder power characterisation.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  ST_IDLE  | waiting for start; a/b hold the last pattern
//  ST_RUN   | presenting pattern pat_idx with valid=1, one per cycle
//  ST_DRAIN | flush cycles; a/b/pat_idx hold, valid=0
//
// Output flops are loaded with the pattern of the *next* cycle, so the
// accepting edge already places pattern 0 on a/b.
module adder_tpg_gen
    import adder_tpg_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               STEP         = 511,
    parameter int               PATTERNS     = 128,
    parameter int               DRAIN_CYCLES = 3,
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(1),
    localparam int              IDX_W        = (PATTERNS > 1) ? $clog2(PATTERNS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    output logic [IDX_W-1:0] pat_idx,
    output logic             busy,
    output logic             done
);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("adder_tpg_gen: WIDTH must be 8, 16, 32 or 64");
    end
    if (PATTERNS < 1) begin : g_bad_patterns
        $error("adder_tpg_gen: PATTERNS must be at least 1");
    end
    if (DRAIN_CYCLES < 0) begin : g_bad_drain
        $error("adder_tpg_gen: DRAIN_CYCLES must be non-negative");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("adder_tpg_gen: SEED must be nonzero");
    end

    localparam int               HALF       = WIDTH / 2;
    localparam int               CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    tpg_state_e       state_q, state_d;
    tpg_mode_e        mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             lfsr_load;
    logic             lfsr_adv;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] lfsr_next;

    // Ingredients of the pattern to be presented next cycle.
    logic             pat_en;
    tpg_mode_e        pat_mode;
    logic [WIDTH-1:0] pat_acc;
    logic [WIDTH-1:0] pat_lfsr;
    logic [WIDTH-1:0] pat_walk;
    logic             pat_odd;

    adder_tpg_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .seed       (SEED),
        .advance    (lfsr_adv),
        .state      (lfsr_state),
        .state_next (lfsr_next)
    );

    // FSM next-state, index/accumulator/drain-timer updates and next-pattern selection.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        pat_en    = 1'b0;
        pat_mode  = mode_q;
        pat_acc   = acc_q + STEP_W;
        pat_lfsr  = lfsr_next;
        pat_walk  = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        pat_odd   = ~idx_q[0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    mode_d    = tpg_mode_e'(mode);
                    idx_d     = '0;
                    acc_d     = '0;
                    lfsr_load = 1'b1;
                    pat_en    = 1'b1;
                    pat_mode  = tpg_mode_e'(mode);
                    pat_acc   = '0;
                    pat_lfsr  = SEED;
                    pat_walk  = WIDTH'(1);
                    pat_odd   = 1'b0;
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    acc_d    = pat_acc;
                    lfsr_adv = 1'b1;
                    pat_en   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output mux: build the next a/b from the selected mode; hold otherwise.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (pat_en) begin
            case (pat_mode)
                MODE_RAMP: begin
                    a_d = ~pat_acc;
                    b_d = pat_acc + WIDTH'(1);
                end
                MODE_LFSR: begin
                    a_d = pat_lfsr;
                    b_d = {pat_lfsr[HALF-1:0], pat_lfsr[WIDTH-1:HALF]};
                end
                MODE_WALK: begin
                    a_d = pat_walk;
                    b_d = '1;
                end
                default: begin
                    a_d = pat_odd ? '1 : '0;
                    b_d = pat_odd ? WIDTH'(1) : '0;
                end
            endcase
        end
        valid_d = (state_d == ST_RUN);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RAMP;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign valid   = valid_q;
    assign pat_idx = idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
